// File: rtl/util_axis_1553_string_decoder.sv
// util_axis_1553_string_decoder: decodes one 22-char ASCII 1553 word string beat into a 16-bit word plus TUSER descriptor
// Single registered output stage; s_axis_tready is combinational from the output state.
module util_axis_1553_string_decoder (
    input  logic         aclk,
    input  logic         arst,
    input  logic [175:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [15:0]  m_axis_tdata,
    output logic [7:0]   m_axis_tuser,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready
);
    logic [7:0]  c [22];
    logic [4:0]  h3, h2, h1, h0;
    logic [1:0]  fd, fp, fi;
    logic [2:0]  typ;
    logic        type_err, lit_err, err;
    logic [15:0] dec_data;
    logic [7:0]  dec_user;
    logic        accept;

    for (genvar g = 0; g < 22; g++) begin : g_chars
        assign c[g] = s_axis_tdata[175-8*g -: 8];
    end

    // {error, nibble}
    function automatic logic [4:0] hex_nib(input logic [7:0] ch);
        logic [7:0] d;
        d = (ch >= "0" && ch <= "9") ? ch - 8'h30 :
            (ch >= "A" && ch <= "F") ? ch - 8'h37 :
            (ch >= "a" && ch <= "f") ? ch - 8'h57 : 8'h10;
        return d[4] ? 5'h10 : {1'b0, d[3:0]};
    endfunction

    // {error, bit}
    function automatic logic [1:0] flag_bit(input logic [7:0] ch);
        return (ch == "0") ? 2'b00 : (ch == "1") ? 2'b01 : 2'b10;
    endfunction

    always_comb begin
        h3       = hex_nib(c[16]);
        h2       = hex_nib(c[17]);
        h1       = hex_nib(c[18]);
        h0       = hex_nib(c[19]);
        fd       = flag_bit(c[6]);
        fp       = flag_bit(c[9]);
        fi       = flag_bit(c[12]);
        typ      = ({c[0], c[1], c[2], c[3]} == "DATA") ? 3'b010 :
                   ({c[0], c[1], c[2], c[3]} == "CMDS") ? 3'b100 : 3'b000;
        type_err = (typ == 3'b000);
        lit_err  = (c[4] != ";") | (c[7] != ";") | (c[10] != ";") | (c[13] != ";") |
                   (c[5] != "D") | (c[8] != "P") | (c[11] != "I") | (c[14] != "H") |
                   (c[15] != "x") | (c[20] != 8'h0D) | (c[21] != 8'h0A);
        err      = type_err | lit_err | fd[1] | fp[1] | fi[1] | h3[4] | h2[4] | h1[4] | h0[4];
        dec_data = {h3[3:0], h2[3:0], h1[3:0], h0[3:0]};
        dec_user = {typ, 1'b0, err, fd[0], fp[0], fi[0]};
    end

    assign s_axis_tready = ~arst & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= dec_data;
            m_axis_tuser  <= dec_user;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_util_axis_1553_string_decoder.sv
// tb_util_axis_1553_string_decoder: directed bench with an expected-word queue checked against every valid output cycle
module tb_util_axis_1553_string_decoder;
    logic         tb_data_clk = 1'b0;
    logic         arst;
    logic [175:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [15:0]  m_axis_tdata;
    logic [7:0]   m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    util_axis_1553_string_decoder dut (
        .aclk          (tb_data_clk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 tb_data_clk = ~tb_data_clk;

    int          total = 0;
    int          bad = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic        acc;
    logic [23:0] q [$];
    logic [15:0] cur_data;
    logic [7:0]  cur_user;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [175:0] s2b(input string s);
        logic [175:0] r;
        r = '0;
        for (int i = 0; i < 22; i++) r[175-8*i -: 8] = s[i];
        return r;
    endfunction

    // One cycle: inputs are stable here (1 ns after the falling edge), so the
    // handshakes seen now are the ones the next rising edge will take.
    task automatic tick();
        #1;
        acc = 1'b0;
        if (m_axis_tvalid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(m_axis_tvalid), 32'd0);
            end else begin
                chk("out_data", 32'(m_axis_tdata), 32'(q[0][23:8]));
                chk("out_user", 32'(m_axis_tuser), 32'(q[0][7:0]));
                if (m_axis_tready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (s_axis_tvalid && s_axis_tready) begin
            q.push_back({cur_data, cur_user});
            n_acc++;
            acc = 1'b1;
        end
        @(posedge tb_data_clk);
        @(negedge tb_data_clk);
    endtask

    task automatic send(input logic [175:0] b, input logic [15:0] ed, input logic [7:0] eu, input logic rnd);
        int n;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        cur_data      = ed;
        cur_user      = eu;
        n = 0;
        do begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [175:0] b;
        string        hx;
        arst          = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cur_data      = '0;
        cur_user      = '0;
        repeat (4) @(negedge tb_data_clk);
        #1;
        chk("ready_in_reset", 32'(s_axis_tready), 32'd0);
        @(negedge tb_data_clk);
        arst = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'h0000);
        chk("rst_tuser", 32'(m_axis_tuser), 32'h00);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        @(negedge tb_data_clk);

        send(s2b("DATA;D1;P1;I0;HxA5F0\r\n"), 16'hA5F0, 8'h46, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        chk("data_popped", 32'(q.size()), 32'd0);
        tick();
        chk("one_cycle_valid", 32'(m_axis_tvalid), 32'd0);

        send(s2b("CMDS;D0;P0;I1;Hxffff\r\n"), 16'hFFFF, 8'h81, 1'b0);
        drain();

        // Last hex char '0'..'9' then ':' back to back
        for (int k = 0; k <= 10; k++) begin
            b = s2b("DATA;D1;P1;I0;HxA5F0\r\n");
            b[23:16] = 8'(8'h30 + k);
            send(b, (k == 10) ? 16'hA5F0 : 16'hA5F0 + 16'(k), (k == 10) ? 8'h4E : 8'h46, 1'b0);
        end
        drain();

        // Random downstream stalls with continuous input
        for (int k = 0; k < 24; k++) begin
            hx = (k < 16) ? "0123456789ABCDEF" : "0123456789abcdef";
            b = s2b("DATA;D1;P1;I0;HxA5F0\r\n");
            b[23:16] = hx[k % 16];
            send(b, 16'hA5F0 | 16'(k % 16), 8'h46, 1'b1);
        end
        drain();
        chk("in_out_count", 32'(n_out), 32'(n_acc));

        // Bad type and flag, then reset while stalled
        m_axis_tready = 1'b0;
        send(s2b("XXXX;D2;P1;I0;HxA5F0\r\n"), 16'hA5F0, 8'h0A, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        chk("stall_tready", 32'(s_axis_tready), 32'd0);
        arst = 1'b1;
        tick();
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(m_axis_tdata), 32'h0000);
        chk("mid_rst_tuser", 32'(m_axis_tuser), 32'h00);
        q.delete();
        arst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("post_rst_tready", 32'(s_axis_tready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/util_axis_1553_string_decoder.md
Name: util_axis_1553_string_decoder

Overview:
Converts one fixed-format 22-character ASCII 1553 word string, presented as a single 176-bit AXI-Stream beat, into a binary 16-bit 1553 data word plus an 8-bit TUSER descriptor. It sits between a UART/string command path and the binary 1553 encoder. Decoding takes one beat in and produces one beat out, with full AXIS back-pressure.

Parameters:
None. All widths are fixed.

Ports:
aclk  in  1  single clock; all logic is on its rising edge
arst  in  1  reset, synchronous and active-high
s_axis_tdata  in  176  22 ASCII chars; first char in [175:168], last in [7:0]
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid and tready are both high
m_axis_tdata  out  16  decoded 1553 data word
m_axis_tuser  out  8  decoded descriptor (layout below)
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: m_axis_tdata=0, m_axis_tuser=0, m_axis_tvalid=0. s_axis_tready=0 while arst=1.
- Input string format, 22 chars: TTTT;D<d>;P<d>;I<d>;Hx<h3><h2><h1><h0>\r\n. Example: "DATA;D1;P1;I0;HxA5F0" followed by 0x0D 0x0A.
- Type token TTTT:
  - "DATA" gives type 3'b010.
  - "CMDS" gives type 3'b100.
  - Any other value gives type 3'b000 and sets the error flag.
  - Matching is case-sensitive.
- Flag digits <d>: '0' decodes to 0, '1' decodes to 1. Any other char decodes to 0 and sets the error flag.
- Hex digits: '0'-'9', 'A'-'F' and 'a'-'f' decode to nibble values. Any other char decodes to nibble 0 and sets the error flag.
- m_axis_tdata = {h3,h2,h1,h0}, with h3 the first hex char.
- Fixed literals must match exactly: ';' at chars 4, 7, 10 and 13; 'D' at 5; 'P' at 8; 'I' at 11; 'H' at 14; 'x' at 15; 0x0D at 20; 0x0A at 21. Char indices count from 0 at the MSB end. Any mismatch sets the error flag.
- m_axis_tuser layout:
  - [7:5] type
  - [4] reserved, always 0
  - [3] error
  - [2] D flag
  - [1] P flag
  - [0] I flag
- Errored strings are still emitted with their best-effort decode. They are never dropped.
- Handshake: a single output register stage.
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready, forced to 0 during reset.
  - On accept, the decoded word loads into the output registers and m_axis_tvalid=1 on the next cycle. Latency is 1 cycle.
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata, tuser and tvalid hold stable and no input is accepted.
  - When the output is consumed and a new input is accepted in the same cycle, the new word loads and tvalid stays 1, giving back-to-back throughput of one word per cycle.
  - When the output is consumed with no new input, tvalid goes to 0.
- s_axis_tdata is only sampled on accept. Input changes without tvalid are ignored.
- Reset asserted mid-transfer: the pending output is discarded and all outputs return to their reset values on the next edge.

Test Plan:
- Reset held 4 cycles, then released -> m_axis_tvalid=0, tdata=0x0000, tuser=0x00; s_axis_tready=1 after release.
- "DATA;D1;P1;I0;HxA5F0\r\n" with m_axis_tready=1 -> one cycle later tdata=0xA5F0, tuser=0x46, tvalid=1 for one cycle.
- "CMDS;D0;P0;I1;Hxffff\r\n" -> tdata=0xFFFF, tuser=0x81.
- Last hex char incremented each accept ('0' through '9', then ':') -> tdata steps 0xA5F0 through 0xA5F9 with tuser=0x46; for ':' tdata=0xA5F0 and tuser=0x4E (error set).
- Random m_axis_tready with continuous s_axis_tvalid -> no word lost or duplicated, outputs stable while stalled, exactly one output beat per input accept, in order.
- "XXXX;D2;P1;I0;HxA5F0\r\n" (bad type, bad flag) -> tdata=0xA5F0, tuser=0x0A; reset asserted while tvalid=1 and tready=0 -> tvalid=0 on the next edge.
